// File: rtl/operand_mux_stage_pkg.sv
// Core-wide definitions shared by the EX-stage datapath blocks.
// Holds the default datapath width and the forwarding-source encoding for the 3-input operand mux.
package pkg_core_defs;

    localparam int XLEN       = 32;
    localparam int FWD_NUM_IN = 3;

    typedef enum logic [1:0] {
        FWD_RF     = 2'd0,
        FWD_EX_MEM = 2'd1,
        FWD_MEM_WB = 2'd2
    } fwd_sel_e;

endpackage

// File: rtl/operand_mux_stage_skid.sv
// Two-entry valid/ready register slice: a main register that drives the output
// and a skid register that absorbs the one beat in flight when the consumer stalls.
module skid_buffer #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] in_data,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] out_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic         accept
);

    logic         main_valid_p1;
    logic [W-1:0] main_data_p1;
    logic         skid_valid_p1;
    logic [W-1:0] skid_data_p1;
    logic         in_ready_p1;

    logic         main_valid_d;
    logic [W-1:0] main_data_d;
    logic         skid_valid_d;
    logic [W-1:0] skid_data_d;
    logic         emit;

    assign accept    = in_valid && in_ready_p1;
    assign emit      = main_valid_p1 && out_ready;
    assign in_ready  = in_ready_p1;
    assign out_valid = main_valid_p1;
    assign out_data  = main_data_p1;

    always_comb begin
        main_valid_d = main_valid_p1;
        main_data_d  = main_data_p1;
        skid_valid_d = skid_valid_p1;
        skid_data_d  = skid_data_p1;
        if (!main_valid_p1 || emit) begin
            if (skid_valid_p1) begin
                // in_ready is low whenever the skid is full, so nothing is accepted here.
                main_valid_d = 1'b1;
                main_data_d  = skid_data_p1;
                skid_valid_d = 1'b0;
            end else begin
                main_valid_d = accept;
                if (accept) begin
                    main_data_d = in_data;
                end
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_data_d  = in_data;
        end
    end

    // Stage boundary: main/skid registers and the registered ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_p1 <= 1'b0;
            main_data_p1  <= '0;
            skid_valid_p1 <= 1'b0;
            skid_data_p1  <= '0;
            in_ready_p1   <= 1'b0;
        end else begin
            main_valid_p1 <= main_valid_d;
            main_data_p1  <= main_data_d;
            skid_valid_p1 <= skid_valid_d;
            skid_data_p1  <= skid_data_d;
            in_ready_p1   <= !skid_valid_d;
        end
    end

endmodule

// File: rtl/operand_mux_stage.sv
// EX-stage operand select: N:1 mux with out-of-range detection, feeding a
// registered skid-buffered output, plus a saturating count of bad-select beats.
module operand_mux_stage
    import pkg_core_defs::*;
#(
    parameter int               WIDTH       = XLEN,
    parameter int               NUM_IN      = FWD_NUM_IN,
    parameter int               SEL_W       = $clog2(NUM_IN),
    parameter logic [WIDTH-1:0] DEFAULT_VAL = '0,
    parameter int               ERR_CNT_W   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_err,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ERR_CNT_W-1:0]    err_count
);

    // Only the addressed slice is read, so X on unselected inputs cannot leak through.
    function automatic logic [WIDTH:0] select_operand(
        input logic [NUM_IN*WIDTH-1:0] data,
        input logic [SEL_W-1:0]        sel
    );
        logic [WIDTH:0] res;
        res = {1'b1, DEFAULT_VAL};
        for (int k = 0; k < NUM_IN; k++) begin
            if (sel == SEL_W'(k)) begin
                res = {1'b0, data[k*WIDTH +: WIDTH]};
            end
        end
        return res;
    endfunction

    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] cnt);
        return (&cnt) ? cnt : cnt + ERR_CNT_W'(1);
    endfunction

    logic [WIDTH:0] beat_p0;
    logic [WIDTH:0] beat_p1;
    logic           accept;

    assign beat_p0 = select_operand(in_data, in_sel);

    skid_buffer #(
        .W(WIDTH + 1)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .in_data  (beat_p0),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .out_data (beat_p1),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .accept   (accept)
    );

    assign out_err  = beat_p1[WIDTH];
    assign out_data = beat_p1[WIDTH-1:0];

    // Stage boundary: error statistics, counted at accept time.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= '0;
        end else if (accept && beat_p0[WIDTH]) begin
            err_count <= sat_inc(err_count);
        end
    end

endmodule
